// File: rtl/gcn_readout_pkg.sv
// rtl/gcn_readout_pkg.sv - shared defaults and sender state type for the readout row sender
package gcn_readout_pkg;

  localparam int DEF_FEATURE_ROWS   = 6;
  localparam int DEF_WEIGHT_COLS    = 3;
  localparam int DEF_DOT_PROD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PRESENT,
    ADVANCE,
    DONE
  } sender_state_t;

endpackage

// File: rtl/fm_wm_adj_row_sender_if.sv
// rtl/fm_wm_adj_row_sender_if.sv - fill stream and arg-max row bus of the row sender
interface fm_wm_adj_row_sender_if
  import gcn_readout_pkg::*;
#(
  parameter int FEATURE_ROWS          = DEF_FEATURE_ROWS,
  parameter int WEIGHT_COLS           = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH        = DEF_DOT_PROD_WIDTH,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
);

  logic                             wr_valid;
  logic                             wr_ready;
  logic [DOT_PROD_WIDTH-1:0]        wr_data;
  logic [DOT_PROD_WIDTH-1:0]        fm_wm_adj_row_out [0:WEIGHT_COLS-1];
  logic                             argmax_read;
  logic                             argmax_write;
  logic [COUNTER_FEATURE_WIDTH-1:0] argmax_row_idx;
  logic [COUNTER_FEATURE_WIDTH-1:0] send_row;

  modport slave (
    input  wr_valid, wr_data, argmax_row_idx,
    output wr_ready, fm_wm_adj_row_out, argmax_read, argmax_write, send_row
  );

  modport master (
    output wr_valid, wr_data, argmax_row_idx,
    input  wr_ready, fm_wm_adj_row_out, argmax_read, argmax_write, send_row
  );

endinterface

// File: rtl/rc_addr_counter.sv
// rtl/rc_addr_counter.sv - row-major fill address counter with wrap and last-element flag
module rc_addr_counter
  import gcn_readout_pkg::*;
#(
  parameter int ROWS = DEF_FEATURE_ROWS,
  parameter int COLS = DEF_WEIGHT_COLS,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  assign last = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col == LAST_COL) begin
        row <= row + RW'(1);
        col <= '0;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fm_wm_adj_row_sender.sv
// rtl/fm_wm_adj_row_sender.sv - buffers the product matrix and presents it row by row to arg-max
module fm_wm_adj_row_sender
  import gcn_readout_pkg::*;
#(
  parameter int FEATURE_ROWS          = DEF_FEATURE_ROWS,
  parameter int WEIGHT_COLS           = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH        = DEF_DOT_PROD_WIDTH,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  fm_wm_adj_row_sender_if.slave       bus,
  output logic                        done,
  output logic                        sync_err
);

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

  sender_state_t                    state_q, state_d;
  logic [COUNTER_FEATURE_WIDTH-1:0] wr_row, send_row_q;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  wr_col;
  logic                             wr_last, wr_ready, wr_fire, presenting;
  logic [DOT_PROD_WIDTH-1:0]        mem [FEATURE_ROWS][WEIGHT_COLS];

  assign wr_fire = bus.wr_valid && wr_ready;

  rc_addr_counter #(
    .ROWS (FEATURE_ROWS),
    .COLS (WEIGHT_COLS),
    .RW   (COUNTER_FEATURE_WIDTH),
    .CW   (COUNTER_WEIGHT_WIDTH)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_fire),
    .row   (wr_row),
    .col   (wr_col),
    .last  (wr_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wr_ready   = 1'b0;
    presenting = 1'b0;
    unique case (state_q)
      IDLE, FILL, DONE: begin
        wr_ready = 1'b1;
        if (wr_fire) state_d = wr_last ? PRESENT : FILL;
      end
      PRESENT: begin
        presenting = 1'b1;
        state_d    = ADVANCE;
      end
      ADVANCE: begin
        presenting = 1'b1;
        state_d    = (send_row_q == LAST_ROW) ? DONE : PRESENT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.argmax_read  = (state_q == PRESENT);
  assign bus.argmax_write = (state_q == ADVANCE);
  assign bus.send_row     = send_row_q;
  assign done             = (state_q == DONE);

  // The row is muxed from storage for both PRESENT and ADVANCE so it is stable across the pair.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      bus.fm_wm_adj_row_out[c] = presenting ? mem[send_row_q][c] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_row_q <= '0;
      sync_err   <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else begin
      if (wr_fire) mem[wr_row][wr_col] <= bus.wr_data;
      if (state_q == ADVANCE) begin
        send_row_q <= (send_row_q == LAST_ROW) ? '0 : send_row_q + COUNTER_FEATURE_WIDTH'(1);
      end
      if ((state_q == PRESENT) && (bus.argmax_row_idx != send_row_q)) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fm_wm_adj_row_sender.sv
// tb/tb_fm_wm_adj_row_sender.sv - scoreboard bench for the arg-max row sender
module tb_fm_wm_adj_row_sender;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int W    = 16;
  localparam int RW   = 3;

  logic clk = 1'b0;
  logic reset;
  logic done, sync_err;

  always #5 clk = ~clk;

  fm_wm_adj_row_sender_if #(
    .FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .DOT_PROD_WIDTH(W), .COUNTER_FEATURE_WIDTH(RW)
  ) bus ();

  fm_wm_adj_row_sender #(
    .FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .DOT_PROD_WIDTH(W),
    .COUNTER_FEATURE_WIDTH(RW), .COUNTER_WEIGHT_WIDTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .done     (done),
    .sync_err (sync_err)
  );

  typedef struct packed {
    logic [RW-1:0]     idx;
    logic [3*W-1:0]    row;
  } exp_t;

  int          n_cmp;
  int          n_err;
  logic        exp_err;
  exp_t        exp_q[$];
  logic [W-1:0] mat [ROWS][COLS];

  function automatic logic [3*W-1:0] row_now();
    return {bus.fm_wm_adj_row_out[0], bus.fm_wm_adj_row_out[1], bus.fm_wm_adj_row_out[2]};
  endfunction

  task automatic load_basic();
    mat = '{'{16'd5, 16'd9, 16'd2}, '{16'd7, 16'd1, 16'd3}, '{16'd0, 16'd0, 16'd4},
            '{16'd8, 16'd8, 16'd1}, '{16'd2, 16'd6, 16'd6}, '{16'd1, 16'd1, 16'd1}};
  endtask

  task automatic load_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mat[r][c] = 16'($urandom_range(0, 16'hFFFE));
  endtask

  // Drives one matrix; the last handshake's clock edge is the one after this task returns.
  task automatic fill(input bit gapped);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        if (bus.argmax_read !== 1'b0 || bus.wr_ready !== 1'b1) begin
          n_err++;
          $display("FAIL fill_state r%0d c%0d: read=%b ready=%b, required read=0 ready=1",
                   r, c, bus.argmax_read, bus.wr_ready);
        end
        n_cmp++;
        if (r != 0 || c != 0) begin
          if (done !== 1'b0) begin
            n_err++;
            $display("FAIL fill_done r%0d c%0d: done=%b, required 0", r, c, done);
          end
          n_cmp++;
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = mat[r][c];
        if (c == COLS - 1) exp_q.push_back('{idx: r[RW-1:0], row: {mat[r][0], mat[r][1], mat[r][2]}});
        if (gapped && !(r == ROWS - 1 && c == COLS - 1)) begin
          @(negedge clk);
          if (bus.argmax_read !== 1'b0) begin
            n_err++;
            $display("FAIL gap_no_present r%0d c%0d: read=%b, required 0", r, c, bus.argmax_read);
          end
          n_cmp++;
          bus.wr_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic readout(input bit hold, input bit bad, input int stop_k);
    exp_t       cur;
    logic [3:0] ctl_exp, ctl_got;
    cur = '0;
    for (int k = 1; k <= stop_k; k++) begin
      @(negedge clk);
      if (k % 2 == 1 && k <= 2 * ROWS - 1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty k=%0d: got no entry, required one", k);
        end else begin
          cur = exp_q.pop_front();
        end
        n_cmp++;
      end
      ctl_exp = (k > 2 * ROWS) ? 4'b0011 : ((k % 2 == 1) ? 4'b1000 : 4'b0100);
      ctl_got = {bus.argmax_read, bus.argmax_write, bus.wr_ready, done};
      if (ctl_got !== ctl_exp) begin
        n_err++;
        $display("FAIL ctl k=%0d: {read,write,ready,done}=%b, required %b", k, ctl_got, ctl_exp);
      end
      n_cmp++;
      if (k <= 2 * ROWS) begin
        if (bus.send_row !== cur.idx || row_now() !== cur.row) begin
          n_err++;
          $display("FAIL row k=%0d: send_row=%0d row=%h, required send_row=%0d row=%h",
                   k, bus.send_row, row_now(), cur.idx, cur.row);
        end
      end else begin
        if (bus.send_row !== '0 || row_now() !== '0) begin
          n_err++;
          $display("FAIL done_row k=%0d: send_row=%0d row=%h, required 0 and 0", k, bus.send_row, row_now());
        end
      end
      n_cmp++;
      if (bad && k == 6) exp_err = 1'b1;
      if (sync_err !== exp_err) begin
        n_err++;
        $display("FAIL sync_err k=%0d: got %b, required %b", k, sync_err, exp_err);
      end
      n_cmp++;
      if (k % 2 == 1 && k <= 2 * ROWS - 1)
        bus.argmax_row_idx = (bad && cur.idx == 3'd2) ? 3'd3 : cur.idx;
      bus.wr_valid = hold && (k <= 2 * ROWS);
      bus.wr_data  = hold ? 16'hFFFF : 16'h0000;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.argmax_row_idx = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    if ({bus.argmax_read, bus.argmax_write, bus.wr_ready, done, sync_err} !== 5'b00100 ||
        bus.send_row !== '0 || row_now() !== '0) begin
      n_err++;
      $display("FAIL reset: read=%b write=%b ready=%b done=%b err=%b row=%0d data=%h, required ready=1 rest 0",
               bus.argmax_read, bus.argmax_write, bus.wr_ready, done, sync_err, bus.send_row, row_now());
    end
    n_cmp++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    load_basic();
    fill(1'b0);
    readout(1'b0, 1'b0, 13);
  endtask

  task automatic test_backpressure();
    load_random();
    fill(1'b0);
    readout(1'b1, 1'b0, 13);
  endtask

  task automatic test_gapped();
    load_basic();
    fill(1'b1);
    readout(1'b0, 1'b0, 13);
  endtask

  task automatic test_sync_err();
    load_basic();
    fill(1'b0);
    readout(1'b0, 1'b1, 13);
  endtask

  task automatic test_back_to_back();
    load_random();
    fill(1'b0);
    readout(1'b0, 1'b0, 13);
  endtask

  task automatic test_async_reset();
    load_random();
    fill(1'b0);
    readout(1'b0, 1'b0, 7);
    #2 reset = 1'b0;
    #1;
    if ({bus.argmax_read, bus.argmax_write, bus.wr_ready, done, sync_err} !== 5'b00100 ||
        bus.send_row !== '0 || row_now() !== '0) begin
      n_err++;
      $display("FAIL async_reset: read=%b write=%b ready=%b done=%b err=%b row=%0d data=%h, required ready=1 rest 0",
               bus.argmax_read, bus.argmax_write, bus.wr_ready, done, sync_err, bus.send_row, row_now());
    end
    n_cmp++;
    exp_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    load_random();
    fill(1'b0);
    readout(1'b0, 1'b0, 13);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_sync_err();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
